// File: rtl/btn_pkg.sv
// Shared state encoding, default timing constants and counter sizing for the
// push-button conditioner (optional auto-repeat is enabled with BTN_AUTOREPEAT_EN).
package btn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } btn_state_e;

   localparam int BTN_N_DEFAULT             = 2;
   localparam int BTN_DEBOUNCE_DEFAULT      = 250000;
   localparam int BTN_REPEAT_DELAY_DEFAULT  = 50000000;
   localparam int BTN_REPEAT_PERIOD_DEFAULT = 10000000;

   // One counter serves debounce and repeat timing, so it is sized for the longest.
   function automatic int btn_cnt_width(input int debounce, input int rdelay, input int rperiod);
      int m;
      m = debounce;
      if (rdelay > m) m = rdelay;
      if (rperiod > m) m = rperiod;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-button conditioner: 2-flop synchronizer, 4-state debounce FSM and a
// shared counter; with BTN_AUTOREPEAT_EN the counter also times repeat presses.
module debounce_channel
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
   parameter int REPEAT_DELAY    = BTN_REPEAT_DELAY_DEFAULT,
   parameter int REPEAT_PERIOD   = BTN_REPEAT_PERIOD_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_level,
   output logic o_press,
   output logic o_release
);

   localparam int CNT_W = btn_cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             w_s;
   btn_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_press;
   logic             r_release;

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

   // Cleared while waiting for the first repeat, set once the periodic phase starts.
   logic r_rep_phase;
   logic w_rep_fire;

   assign w_rep_fire = r_rep_phase ? (r_cnt == RPT_PERIOD_LAST)
                                   : (r_cnt == RPT_DELAY_LAST);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = r_sync2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         r_rep_phase <= 1'b0;
`endif
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_s) begin
                  r_state <= ST_PRESS_WAIT;
                  r_cnt   <= '0;
               end
            end
            ST_PRESS_WAIT: begin
               if (!w_s) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == DB_LAST) begin
                  r_state <= ST_HELD;
                  r_cnt   <= '0;
                  r_level <= 1'b1;
                  r_press <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                  r_rep_phase <= 1'b0;
`endif
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_HELD: begin
               if (!w_s) begin
                  r_state <= ST_RELEASE_WAIT;
                  r_cnt   <= '0;
`ifdef BTN_AUTOREPEAT_EN
                  r_rep_phase <= 1'b0;
               end else if (w_rep_fire) begin
                  r_press     <= 1'b1;
                  r_cnt       <= '0;
                  r_rep_phase <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
`endif
               end
            end
            ST_RELEASE_WAIT: begin
               // A bounce back to pressed re-enters HELD with fresh repeat timing.
               if (w_s) begin
                  r_state <= ST_HELD;
                  r_cnt   <= '0;
`ifdef BTN_AUTOREPEAT_EN
                  r_rep_phase <= 1'b0;
`endif
               end else if (r_cnt == DB_LAST) begin
                  r_state   <= ST_IDLE;
                  r_cnt     <= '0;
                  r_level   <= 1'b0;
                  r_release <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;

endmodule

// File: rtl/button_conditioner.sv
// Bank of independent push-button conditioners feeding the up/down LED counter;
// define BTN_AUTOREPEAT_EN to add hold-to-repeat press pulses on every channel.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int N_BTN           = BTN_N_DEFAULT,
   parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
   parameter int REPEAT_DELAY    = BTN_REPEAT_DELAY_DEFAULT,
   parameter int REPEAT_PERIOD   = BTN_REPEAT_PERIOD_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);

   genvar g;
   generate
      for (g = 0; g < N_BTN; g++) begin : g_chan
         debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
         ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .i_btn     (btn_in[g]),
            .o_level   (btn_level[g]),
            .o_press   (btn_press[g]),
            .o_release (btn_release[g])
         );
      end
   endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Directed scoreboard bench for button_conditioner: expected pulse events are
// queued as stimulus is applied and matched against pulses seen on the outputs.
module tb_button_conditioner;

   localparam int DB  = 4;
   localparam int RD  = 10;
   localparam int RP  = 3;
   localparam int LAT = DB + 3;

   typedef struct packed {
      int unsigned cyc;
      logic [1:0]  press;
      logic [1:0]  rel;
      logic [1:0]  lvl;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] btn_in;
   logic [1:0] btn_level;
   logic [1:0] btn_press;
   logic [1:0] btn_release;
   logic [0:0] btn1_in;
   logic [0:0] lvl1;
   logic [0:0] press1;
   logic [0:0] rel1;

   int unsigned ecnt = 0;
   int          checks = 0;
   int          failures = 0;
   ev_t         exp_q[$];
   ev_t         obs_q[$];

   always #5 clk = ~clk;

   button_conditioner #(
      .N_BTN(2), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) u_dut (
      .clk(clk), .rst(rst), .btn_in(btn_in),
      .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
   );

   button_conditioner #(
      .N_BTN(1), .DEBOUNCE_CYCLES(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) u_d1 (
      .clk(clk), .rst(rst), .btn_in(btn1_in),
      .btn_level(lvl1), .btn_press(press1), .btn_release(rel1)
   );

   always @(posedge clk) ecnt <= ecnt + 1;

   always @(negedge clk) begin
      if (btn_press != 2'b00 || btn_release != 2'b00)
         obs_q.push_back(ev_t'{ecnt, btn_press, btn_release, btn_level});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_events(input string tag);
      ev_t e;
      ev_t o;
      int  n;
      #1;
      chk({tag, " event count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         chk({tag, " event cycle"}, o.cyc, e.cyc);
         chk({tag, " press/release/level"}, {26'd0, o.press, o.rel, o.lvl},
             {26'd0, e.press, e.rel, e.lvl});
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned k;
      int unsigned a;
      int unsigned r;
      rst     = 1'b1;
      btn_in  = 2'b00;
      btn1_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset level", 32'(btn_level), 32'd0);
      chk("reset press", 32'(btn_press), 32'd0);
      chk("reset release", 32'(btn_release), 32'd0);
      chk("reset d1 level", 32'(lvl1), 32'd0);
      rst = 1'b0;

      // Single press, long hold (repeats when enabled), clean release.
      @(negedge clk);
      btn_in = 2'b01;
      k = ecnt;
      a = k + LAT;
      exp_q.push_back(ev_t'{a, 2'b01, 2'b00, 2'b01});
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("press level0", 32'(btn_level[0]), 32'(ecnt >= a));
         chk("idle press1", 32'(btn_press[1]), 32'd0);
      end
`ifdef BTN_AUTOREPEAT_EN
      exp_q.push_back(ev_t'{a + RD, 2'b01, 2'b00, 2'b01});
      exp_q.push_back(ev_t'{a + RD + RP, 2'b01, 2'b00, 2'b01});
      exp_q.push_back(ev_t'{a + RD + 2 * RP, 2'b01, 2'b00, 2'b01});
      exp_q.push_back(ev_t'{a + RD + 3 * RP, 2'b01, 2'b00, 2'b01});
`endif
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         chk("hold level0", 32'(btn_level[0]), 32'd1);
      end
      btn_in = 2'b00;
      r = ecnt;
      exp_q.push_back(ev_t'{r + LAT, 2'b00, 2'b01, 2'b00});
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("release level0", 32'(btn_level[0]), 32'(ecnt < r + LAT));
      end
      check_events("press-hold-release ch0");

      // Bounce shorter than the debounce window.
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         btn_in[0] = ((i % 4) < 2);
         @(negedge clk);
         chk("bounce level0", 32'(btn_level[0]), 32'd0);
      end
      btn_in = 2'b00;
      repeat (10) @(negedge clk);
      chk("bounce level after", 32'(btn_level), 32'd0);
      check_events("bounce");

      // Both buttons on the same edge.
      @(negedge clk);
      btn_in = 2'b11;
      k = ecnt;
      exp_q.push_back(ev_t'{k + LAT, 2'b11, 2'b00, 2'b11});
      repeat (10) @(negedge clk);
      btn_in = 2'b00;
      r = ecnt;
      exp_q.push_back(ev_t'{r + LAT, 2'b00, 2'b11, 2'b00});
      repeat (10) @(negedge clk);
      check_events("both buttons");

      // Asynchronous reset while HELD, then while in PRESS_WAIT.
      @(negedge clk);
      btn_in = 2'b01;
      k = ecnt;
      exp_q.push_back(ev_t'{k + LAT, 2'b01, 2'b00, 2'b01});
      repeat (10) @(negedge clk);
      chk("held level0 before rst", 32'(btn_level[0]), 32'd1);
      check_events("press before rst");
      #2 rst = 1'b1;
      #1;
      chk("rst held level", 32'(btn_level), 32'd0);
      chk("rst held press", 32'(btn_press), 32'd0);
      chk("rst held release", 32'(btn_release), 32'd0);
      repeat (3) @(negedge clk);
      chk("rst hold level", 32'(btn_level), 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      #3 rst = 1'b1;
      #1;
      chk("rst press-wait level", 32'(btn_level), 32'd0);
      chk("rst press-wait press", 32'(btn_press), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      k = ecnt;
      exp_q.push_back(ev_t'{k + LAT, 2'b01, 2'b00, 2'b01});
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("post-rst level0", 32'(btn_level[0]), 32'(ecnt >= k + LAT));
      end
      check_events("press after rst");
      @(negedge clk);
      btn_in = 2'b00;
      r = ecnt;
      exp_q.push_back(ev_t'{r + LAT, 2'b00, 2'b01, 2'b00});
      repeat (10) @(negedge clk);
      check_events("release after rst");

      // Minimum debounce window on the single-channel instance.
      @(negedge clk);
      btn1_in = 1'b1;
      k = ecnt;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("d1 press", 32'(press1), 32'(ecnt == k + 4));
         chk("d1 level", 32'(lvl1), 32'(ecnt >= k + 4));
      end
      btn1_in = 1'b0;
      r = ecnt;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("d1 release", 32'(rel1), 32'(ecnt == r + 4));
         chk("d1 release level", 32'(lvl1), 32'(ecnt < r + 4));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Sits directly upstream of the lab up/down LED counter.
- Converts raw, bouncy push-button inputs into clean per-button signals:
  - a debounced level;
  - a single-cycle press pulse;
  - a single-cycle release pulse.
- The counter consumes the press pulses as its increment/decrement requests.
- One independent conditioning channel per button; all channels share clk and rst.

Parameters:
- N_BTN, 2, number of button channels.
- DEBOUNCE_CYCLES, 250000, consecutive stable synchronized samples required to accept a level change; legal range >= 1.
- REPEAT_DELAY, 50000000, hold cycles before the first auto-repeat pulse (used only with BTN_AUTOREPEAT_EN).
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (used only with BTN_AUTOREPEAT_EN).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- btn_in  input  N_BTN  raw asynchronous button levels, 1 = pressed.
- btn_level  output  N_BTN  debounced level, registered.
- btn_press  output  N_BTN  one-cycle pulse per accepted press (and per auto-repeat).
- btn_release  output  N_BTN  one-cycle pulse per accepted release.

Behaviour:
- Reset:
  - Asynchronous, active-high: one clock `clk`, reset `rst` asynchronous active-high.
  - While rst=1: all synchronizer flops, counters and outputs = 0; every channel in IDLE.
  - Reset asserted mid-debounce or while held aborts the channel immediately, with no release pulse.
  - After rst deasserts with a button already held down, the press is accepted normally (full debounce, then press pulse).
- Synchronizer: each btn_in bit passes through a 2-flop synchronizer; s = output of the second flop.
- Channel FSM, 4 states, counter cnt:
  - IDLE (level 0): s=1 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT:
    - s=0 -> IDLE, no pulse.
    - s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, btn_level<=1, btn_press<=1 for one cycle.
    - Otherwise cnt++.
  - HELD (level 1): s=0 -> RELEASE_WAIT, cnt=0.
  - RELEASE_WAIT:
    - s=1 -> HELD, no pulse.
    - s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, btn_level<=0, btn_release<=1 for one cycle.
    - Otherwise cnt++.
- Latency: first rising edge sampling btn_in=1 is edge 0; btn_press and btn_level go high after edge DEBOUNCE_CYCLES+2 if btn_in is held steady. Release is symmetric.
- Bounce shorter than DEBOUNCE_CYCLES synchronized samples produces no pulse and no level change; cnt restarts from 0 on the next transition.
- Pulses:
  - Registered, exactly one clk cycle wide.
  - btn_press and btn_release never assert together on the same channel.
- Channels are fully independent; simultaneous presses on several buttons yield simultaneous pulses.
- cnt width = $clog2 of the maximum of DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD, minimum 1; cnt never wraps.
- DEBOUNCE_CYCLES=1: a change is accepted on the first FSM sample in the WAIT state.

Optional Feature:
- Macro BTN_AUTOREPEAT_EN.
- Defined:
  - In HELD, cnt counts hold cycles.
  - First extra btn_press pulse after REPEAT_DELAY cycles in HELD, then one every REPEAT_PERIOD cycles while still held.
  - Leaving HELD (entering RELEASE_WAIT) resets the repeat timing.
  - A bounce back into HELD restarts the REPEAT_DELAY count.
  - btn_level stays 1 throughout.
- Undefined: no repeat logic is synthesized; exactly one btn_press per accepted press; REPEAT_* parameters are ignored.

Decomposition:
- Package btn_pkg:
  - state encoding localparams ST_IDLE, ST_PRESS_WAIT, ST_HELD, ST_RELEASE_WAIT (2 bits);
  - default debounce and repeat constants.
- Sub-module debounce_channel: synchronizer + FSM + counter for a single bit, instantiated N_BTN times in a generate loop by button_conditioner.

Test Plan:
- DEBOUNCE_CYCLES=4: rst pulse, then btn_in[0]=1 held -> btn_level[0]=1 and one btn_press[0] pulse after edge 6; btn_press[1]=0 throughout.
- DEBOUNCE_CYCLES=4: btn_in[0] toggles 1,0,1,0 every 2 cycles, then stays 0 -> no pulses, btn_level[0] stays 0.
- Held button released cleanly -> one btn_release[0] pulse 6 edges after release; btn_level[0] falls on the same edge.
- Both buttons pressed on the same edge -> btn_press=2'b11 for exactly one cycle.
- rst asserted asynchronously mid-PRESS_WAIT and mid-HELD -> outputs 0 immediately, no release pulse; press still held after rst deasserts -> press accepted after full debounce.
- BTN_AUTOREPEAT_EN with REPEAT_DELAY=10, REPEAT_PERIOD=3, hold 20 cycles after acceptance -> press pulses at acceptance, then +10, +13, +16, +19.
